btn_event_ctrl: RTL and testbench
=================================

Name: btn_event_ctrl

Overview:
- Turns the five raw board push-buttons into clean, single move events for the 2048 CPU.
- Per button: synchronise, debounce and detect the press edge.
- Arbitrates simultaneous presses into a 4-deep event FIFO.
- The CPU polls and pops the FIFO through the MMIO read path; the game loop sees one event per physical press, with no bounce duplicates.

Parameters:
- N_BTN, 5, number of buttons (btn_i width).
- DB_CNT, 1000000, consecutive stable samples required to accept a level change (10 ms at 100 MHz).
- FIFO_DEPTH, 4, event FIFO entries; must be a power of 2.
- REPEAT_CNT, 25000000, auto-repeat period in cycles; used only with BTN_AUTOREPEAT_EN.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; synchronous, active-low.
- btn_i  in  N_BTN  raw asynchronous button levels (1 = pressed).
- ev_pop  in  1  CPU pop strobe; one-cycle pulse removes the head entry.
- ov_clr  in  1  clears the overflow flag.
- ev_valid  out  1  FIFO non-empty.
- ev_code  out  3  button index at FIFO head (0..4); 0 when empty.
- ev_rep  out  1  head entry is an auto-repeat; always 0 without the macro.
- ev_level  out  3  FIFO occupancy, 0..FIFO_DEPTH.
- overflow  out  1  sticky; set when an event was dropped.
- btn_db_o  out  N_BTN  debounced button levels, for LED mirroring.

Behaviour:
- Reset (rstn=0 at a clk edge) clears synchronisers, counters, pending bits, FIFO pointers and overflow. After reset every output is 0.
  - Reset mid-operation discards queued and in-flight events.
  - A button held through reset release is treated as a new press and yields one event after full debounce.
- Synchroniser: 2-FF chain per button.
- Per-button FSM:
  - States: IDLE (db=0), PRESS_CHK, HELD (db=1), REL_CHK. Counter width is clog2(DB_CNT+1).
  - IDLE → PRESS_CHK when sync=1; the counter loads 1.
  - PRESS_CHK: sync=1 increments the counter. When it reaches DB_CNT, go to HELD, set db=1 and set pending[i]. sync=0 returns to IDLE and clears the counter.
  - HELD → REL_CHK when sync=0.
  - REL_CHK: sync=0 increments the counter; at DB_CNT go to IDLE with db=0. sync=1 returns to HELD. No event on release.
- Latency: btn_i held at 1 from before edge 1 makes ev_valid=1 immediately after edge DB_CNT+3. Edges 1–2 are synchroniser, then DB_CNT samples, then one push edge.
- Arbitration: each cycle, the lowest-index set pending bit is pushed and cleared. Remaining pending bits wait one cycle each, so there is at most one push per cycle. A pending bit that is set again while still pending merges; no second event is created.
- FIFO:
  - Entry = {rep, code[2:0]}. Head is shown combinationally on ev_code and ev_rep.
  - ev_pop while empty is ignored.
  - Push and pop in the same cycle while full: both succeed and the level is unchanged.
  - Push while full without a pop: the event is dropped, its pending bit is cleared, and overflow is set.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow: set-dominant; ov_clr and a drop in the same cycle leave it at 1.

Optional Feature:
- Macro BTN_AUTOREPEAT_EN.
- Defined:
  - A per-button repeat counter runs while in HELD.
  - Every REPEAT_CNT cycles in HELD it sets pending with rep=1.
  - Leaving HELD clears the counter; REL_CHK → HELD restarts it from 0.
- Undefined: no repeat logic is generated; ev_rep is tied to 0.

Decomposition:
- Package btn_pkg:
  - BTN_UP=0, BTN_DOWN=1, BTN_LEFT=2, BTN_RIGHT=3, BTN_CENTER=4.
  - Debounce-state enum.
  - Event-entry struct {rep, code}.
- One sub-module btn_debounce, instantiated N_BTN times: synchroniser, FSM, optional repeat counter.
- The top contains the priority arbiter and the FIFO.

Test Plan (DB_CNT=8, REPEAT_CNT=40 overrides):
- btn_i[1] bounces 1/0 every 3 cycles for 24 cycles, then holds 1 → exactly one event; ev_code=1 appears 11 cycles after the stable level starts; ev_level=1.
- btn_i[0] and btn_i[3] rise in the same cycle and hold → ev_valid 11 cycles later; pops yield codes 0 then 3 in order.
- Six distinct presses with no pops → ev_level=4 and overflow=1. Pops return the first four codes in order. ov_clr then clears overflow.
- FIFO full and a new press is debounced while ev_pop is held high that cycle → ev_level stays 4, overflow stays 0.
- rstn=0 for 1 cycle with 2 queued events and btn_i[2] held → ev_level=0. One event with code 2 appears 11 cycles after rstn returns to 1.
- BTN_AUTOREPEAT_EN defined, btn_i[4] held for 150 cycles → events: 1 normal (rep=0) plus 3 repeats (rep=1) at 40-cycle spacing. Undefined: 1 event only.

Source files
------------

// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Purpose : shared definitions for the push-button event controller.
//           Button index names, the debounce FSM state type and the event FIFO
//           entry layout.
// Ports   : none (package).
// Optional: BTN_AUTOREPEAT_EN (used by btn_debounce / btn_event_ctrl) enables
//           auto-repeat events while a button is held.
// -----------------------------------------------------------------------------
package btn_pkg;

    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_CENTER = 4;

    typedef enum logic [1:0] {
        DB_IDLE      = 2'd0,
        DB_PRESS_CHK = 2'd1,
        DB_HELD      = 2'd2,
        DB_REL_CHK   = 2'd3
    } db_state_t;

    typedef struct packed {
        logic       rep;
        logic [2:0] code;
    } btn_event_t;

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Purpose : one button channel: 2-FF synchroniser, debounce FSM and (with
//           BTN_AUTOREPEAT_EN defined) a held-button repeat counter.
// Ports   : clk      system clock
//           rstn     synchronous active-low reset
//           i_btn    raw asynchronous button level
//           o_db     debounced level (1 in HELD / REL_CHK)
//           o_press  one-cycle request: press accepted this cycle
//           o_rep    one-cycle request: auto-repeat due this cycle
// Macro   : BTN_AUTOREPEAT_EN - when undefined o_rep is constant 0 and no
//           repeat counter exists.
// -----------------------------------------------------------------------------
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DB_CNT     = 1000000,
    parameter int REPEAT_CNT = 25000000
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_btn,
    output logic o_db,
    output logic o_press,
    output logic o_rep
);

    localparam int CW = $clog2(DB_CNT + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT - 1);

    // The FSM needs at least one increment after the load-1 entry step.
    if (DB_CNT < 2) begin : g_bad_db_cnt
        $error("btn_debounce: DB_CNT must be at least 2");
    end
    if (REPEAT_CNT < 2) begin : g_bad_repeat_cnt
        $error("btn_debounce: REPEAT_CNT must be at least 2");
    end

    logic [1:0]    r_sync;
    logic          w_sync;
    db_state_t     r_state;
    db_state_t     w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    assign w_sync = r_sync[1];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sync  <= 2'b00;
            r_state <= DB_IDLE;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // The entry step loads 1, so reaching DB_CNT means the increment happens
    // while the counter holds DB_CNT-1.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        o_press      = 1'b0;
        case (r_state)
            DB_IDLE: begin
                if (w_sync) begin
                    w_state_next = DB_PRESS_CHK;
                    w_cnt_next   = CNT_ONE;
                end
            end
            DB_PRESS_CHK: begin
                if (!w_sync) begin
                    w_state_next = DB_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = DB_HELD;
                    w_cnt_next   = '0;
                    o_press      = 1'b1;
                end else begin
                    w_cnt_next   = r_cnt + CNT_ONE;
                end
            end
            DB_HELD: begin
                if (!w_sync) begin
                    w_state_next = DB_REL_CHK;
                    w_cnt_next   = CNT_ONE;
                end
            end
            DB_REL_CHK: begin
                if (w_sync) begin
                    w_state_next = DB_HELD;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = DB_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_next = DB_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign o_db = (r_state == DB_HELD) || (r_state == DB_REL_CHK);

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CNT + 1);

    logic [RW-1:0] r_rep_cnt;
    logic          w_rep_hit;

    // Counts only cycles that stay in HELD; any exit (including a bounce into
    // REL_CHK) restarts the period from 0.
    assign w_rep_hit = (r_state == DB_HELD) && w_sync
                       && (r_rep_cnt == RW'(REPEAT_CNT - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rep_cnt <= '0;
        end else if ((r_state == DB_HELD) && w_sync) begin
            r_rep_cnt <= w_rep_hit ? '0 : r_rep_cnt + RW'(1);
        end else begin
            r_rep_cnt <= '0;
        end
    end

    assign o_rep = w_rep_hit;
`else
    assign o_rep = 1'b0;
`endif

endmodule

// File: rtl/btn_event_ctrl.sv
// -----------------------------------------------------------------------------
// btn_event_ctrl
// Purpose : debounces N_BTN push-buttons and queues one event per press in a
//           small FIFO polled/popped by the CPU.
// Ports   : clk       system clock
//           rstn      synchronous active-low reset
//           btn_i     raw button levels (1 = pressed)
//           ev_pop    pop strobe, removes head entry (ignored when empty)
//           ov_clr    clears the sticky overflow flag
//           ev_valid  FIFO non-empty
//           ev_code   button index at head, 0 when empty
//           ev_rep    head entry is an auto-repeat, 0 when empty
//           ev_level  FIFO occupancy
//           overflow  sticky: an event was dropped on a full FIFO
//           btn_db_o  debounced button levels
// Macro   : BTN_AUTOREPEAT_EN - enables held-button repeat events (ev_rep=1).
// -----------------------------------------------------------------------------
module btn_event_ctrl
    import btn_pkg::*;
#(
    parameter int N_BTN      = 5,
    parameter int DB_CNT     = 1000000,
    parameter int FIFO_DEPTH = 4,
    parameter int REPEAT_CNT = 25000000
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_BTN-1:0] btn_i,
    input  logic             ev_pop,
    input  logic             ov_clr,
    output logic             ev_valid,
    output logic [2:0]       ev_code,
    output logic             ev_rep,
    output logic [2:0]       ev_level,
    output logic             overflow,
    output logic [N_BTN-1:0] btn_db_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("btn_event_ctrl: FIFO_DEPTH must be a power of 2, at least 2");
    end

    logic [N_BTN-1:0] w_db;
    logic [N_BTN-1:0] w_press;
    logic [N_BTN-1:0] w_rep_set;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        btn_debounce #(
            .DB_CNT     (DB_CNT),
            .REPEAT_CNT (REPEAT_CNT)
        ) u_debounce (
            .clk     (clk),
            .rstn    (rstn),
            .i_btn   (btn_i[gi]),
            .o_db    (w_db[gi]),
            .o_press (w_press[gi]),
            .o_rep   (w_rep_set[gi])
        );
    end

    assign btn_db_o = w_db;

    // ---------------- pending bits and priority arbiter ----------------
    logic [N_BTN-1:0] r_pend;
    logic [N_BTN-1:0] r_pend_rep;
    logic [N_BTN-1:0] w_grant;
    logic             w_found;
    btn_event_t       w_push_entry;

    always_comb begin
        w_grant      = '0;
        w_found      = 1'b0;
        w_push_entry = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (r_pend[i] && !w_found) begin
                w_found           = 1'b1;
                w_grant[i]        = 1'b1;
                w_push_entry.code = 3'(i);
                w_push_entry.rep  = r_pend_rep[i];
            end
        end
    end

    // ---------------- FIFO ----------------
    btn_event_t     r_mem [FIFO_DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [LW-1:0]  r_level;
    logic           r_ov;
    logic           w_pop;
    logic           w_full;
    logic           w_push;
    logic           w_drop;
    btn_event_t     w_head;

    assign w_full = (r_level == LW'(FIFO_DEPTH));
    assign w_pop  = ev_pop && (r_level != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push = w_found && (!w_full || w_pop);
    assign w_drop = w_found && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pend     <= '0;
            r_pend_rep <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_ov       <= 1'b0;
        end else begin
            // Granted bit is consumed (pushed or dropped); new requests merge.
            r_pend     <= (r_pend & ~w_grant) | w_press | w_rep_set;
            r_pend_rep <= (r_pend_rep & ~(w_press | w_rep_set)) | (w_rep_set & ~w_press);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            r_ov <= w_drop | (r_ov & ~ov_clr);
        end
    end

    assign w_head   = r_mem[r_rd_ptr];
    assign ev_valid = (r_level != '0);
    assign ev_code  = ev_valid ? w_head.code : 3'd0;
    assign ev_rep   = ev_valid ? w_head.rep : 1'b0;
    assign ev_level = 3'(r_level);
    assign overflow = r_ov;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// -----------------------------------------------------------------------------
// tb_btn_event_ctrl
// Purpose : directed self-checking bench for btn_event_ctrl with DB_CNT=8 and
//           REPEAT_CNT=40. Expectations for the repeat scenario follow
//           BTN_AUTOREPEAT_EN.
// -----------------------------------------------------------------------------
module tb_btn_event_ctrl;
    import btn_pkg::*;

    localparam int N_BTN = 5;

    logic             clk;
    logic             rstn;
    logic [N_BTN-1:0] btn_i;
    logic             ev_pop;
    logic             ov_clr;
    logic             ev_valid;
    logic [2:0]       ev_code;
    logic             ev_rep;
    logic [2:0]       ev_level;
    logic             overflow;
    logic [N_BTN-1:0] btn_db_o;

    int checks = 0;
    int errors = 0;

    btn_event_ctrl #(
        .N_BTN      (N_BTN),
        .DB_CNT     (8),
        .FIFO_DEPTH (4),
        .REPEAT_CNT (40)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .btn_i    (btn_i),
        .ev_pop   (ev_pop),
        .ov_clr   (ov_clr),
        .ev_valid (ev_valid),
        .ev_code  (ev_code),
        .ev_rep   (ev_rep),
        .ev_level (ev_level),
        .overflow (overflow),
        .btn_db_o (btn_db_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop_once();
        ev_pop = 1'b1;
        tick(1);
        ev_pop = 1'b0;
    endtask

    task automatic press_release(input int idx);
        btn_i[idx] = 1'b1;
        tick(12);
        btn_i[idx] = 1'b0;
        tick(12);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick(2);
        checks++;
        if ({ev_valid, ev_code, ev_rep, ev_level, overflow, btn_db_o} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {ev_valid, ev_code, ev_rep, ev_level, overflow, btn_db_o});
        end
        rstn = 1'b1;
        tick(1);
        checks++;
        if (ev_level !== 3'd0) begin
            errors++;
            $display("FAIL reset_release_level: got %0d required 0", ev_level);
        end
        $display("test_reset: outputs after reset level=%0d", ev_level);
    endtask

    task automatic test_bounce();
        for (int p = 0; p < 4; p++) begin
            btn_i[BTN_DOWN] = 1'b1;
            tick(3);
            btn_i[BTN_DOWN] = 1'b0;
            tick(3);
        end
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL bounce_no_event: got ev_valid=%0b required 0", ev_valid);
        end
        btn_i[BTN_DOWN] = 1'b1;
        tick(10);
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL bounce_early: got ev_valid=%0b required 0 at cycle 10", ev_valid);
        end
        tick(1);
        checks++;
        if ({ev_valid, ev_code, ev_level} !== {1'b1, 3'd1, 3'd1}) begin
            errors++;
            $display("FAIL bounce_event: got valid=%0b code=%0d level=%0d required 1/1/1",
                     ev_valid, ev_code, ev_level);
        end
        tick(20);
        checks++;
        if ({ev_level, btn_db_o} !== {3'd1, 5'b00010}) begin
            errors++;
            $display("FAIL bounce_hold: got level=%0d db=%b required 1/00010", ev_level, btn_db_o);
        end
        btn_i[BTN_DOWN] = 1'b0;
        tick(15);
        checks++;
        if ({ev_level, btn_db_o} !== {3'd1, 5'b00000}) begin
            errors++;
            $display("FAIL bounce_release: got level=%0d db=%b required 1/00000", ev_level, btn_db_o);
        end
        pop_once();
        checks++;
        if ({ev_valid, ev_code, ev_level} !== 7'd0) begin
            errors++;
            $display("FAIL bounce_pop: got valid=%0b code=%0d level=%0d required 0/0/0",
                     ev_valid, ev_code, ev_level);
        end
        $display("test_bounce: one event code=1 after bounce");
    endtask

    task automatic test_simultaneous();
        btn_i[BTN_UP]    = 1'b1;
        btn_i[BTN_RIGHT] = 1'b1;
        tick(10);
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_early: got ev_valid=%0b required 0", ev_valid);
        end
        tick(1);
        checks++;
        if ({ev_valid, ev_code, ev_level} !== {1'b1, 3'd0, 3'd1}) begin
            errors++;
            $display("FAIL simul_first: got valid=%0b code=%0d level=%0d required 1/0/1",
                     ev_valid, ev_code, ev_level);
        end
        tick(1);
        checks++;
        if (ev_level !== 3'd2) begin
            errors++;
            $display("FAIL simul_level2: got %0d required 2", ev_level);
        end
        pop_once();
        checks++;
        if ({ev_code, ev_level} !== {3'd3, 3'd1}) begin
            errors++;
            $display("FAIL simul_second: got code=%0d level=%0d required 3/1", ev_code, ev_level);
        end
        pop_once();
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_empty: got ev_valid=%0b required 0", ev_valid);
        end
        btn_i = '0;
        tick(15);
        $display("test_simultaneous: codes 0 then 3");
    endtask

    task automatic test_overflow();
        int seq [6] = '{0, 1, 2, 3, 4, 0};
        for (int k = 0; k < 6; k++) press_release(seq[k]);
        checks++;
        if ({ev_level, overflow, ev_code} !== {3'd4, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL ovf_full: got level=%0d ovf=%0b code=%0d required 4/1/0",
                     ev_level, overflow, ev_code);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ev_code !== 3'(seq[k])) begin
                errors++;
                $display("FAIL ovf_pop%0d: got code=%0d required %0d", k, ev_code, seq[k]);
            end
            pop_once();
        end
        pop_once();
        checks++;
        if ({ev_level, overflow} !== {3'd0, 1'b1}) begin
            errors++;
            $display("FAIL ovf_empty_pop: got level=%0d ovf=%0b required 0/1", ev_level, overflow);
        end
        ov_clr = 1'b1;
        tick(1);
        ov_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %0b required 0", overflow);
        end
        $display("test_overflow: 6 presses, 4 kept, overflow cleared");
    endtask

    task automatic test_full_push_pop();
        int exp_codes [4] = '{1, 2, 3, 4};
        for (int k = 0; k < 4; k++) press_release(k);
        btn_i[BTN_CENTER] = 1'b1;
        tick(10);
        ev_pop = 1'b1;
        tick(1);
        ev_pop = 1'b0;
        checks++;
        if ({ev_level, overflow, ev_code} !== {3'd4, 1'b0, 3'd1}) begin
            errors++;
            $display("FAIL fullpp: got level=%0d ovf=%0b code=%0d required 4/0/1",
                     ev_level, overflow, ev_code);
        end
        btn_i[BTN_CENTER] = 1'b0;
        tick(12);
        // Drop and clear land on the same edge: overflow must still set.
        btn_i[BTN_UP] = 1'b1;
        tick(10);
        ov_clr = 1'b1;
        tick(1);
        ov_clr = 1'b0;
        checks++;
        if ({ev_level, overflow} !== {3'd4, 1'b1}) begin
            errors++;
            $display("FAIL set_dominant: got level=%0d ovf=%0b required 4/1", ev_level, overflow);
        end
        btn_i[BTN_UP] = 1'b0;
        tick(12);
        ov_clr = 1'b1;
        tick(1);
        ov_clr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ev_code !== 3'(exp_codes[k])) begin
                errors++;
                $display("FAIL fullpp_drain%0d: got code=%0d required %0d", k, ev_code, exp_codes[k]);
            end
            pop_once();
        end
        checks++;
        if ({ev_level, overflow} !== 4'd0) begin
            errors++;
            $display("FAIL fullpp_end: got level=%0d ovf=%0b required 0/0", ev_level, overflow);
        end
        $display("test_full_push_pop: push+pop on full kept level 4");
    endtask

    task automatic test_reset_mid();
        press_release(0);
        press_release(1);
        btn_i[BTN_LEFT] = 1'b1;
        tick(3);
        rstn = 1'b0;
        tick(1);
        rstn = 1'b1;
        checks++;
        if ({ev_valid, ev_level, btn_db_o} !== 9'd0) begin
            errors++;
            $display("FAIL midreset_clear: got valid=%0b level=%0d db=%b required 0/0/0",
                     ev_valid, ev_level, btn_db_o);
        end
        tick(10);
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_early: got ev_valid=%0b required 0", ev_valid);
        end
        tick(1);
        checks++;
        if ({ev_valid, ev_code, ev_level} !== {1'b1, 3'd2, 3'd1}) begin
            errors++;
            $display("FAIL midreset_event: got valid=%0b code=%0d level=%0d required 1/2/1",
                     ev_valid, ev_code, ev_level);
        end
        tick(20);
        btn_i[BTN_LEFT] = 1'b0;
        tick(12);
        checks++;
        if (ev_level !== 3'd1) begin
            errors++;
            $display("FAIL midreset_single: got level=%0d required 1", ev_level);
        end
        pop_once();
        $display("test_reset_mid: held button re-detected after reset");
    endtask

    task automatic test_autorepeat();
`ifdef BTN_AUTOREPEAT_EN
        int exp_n = 4;
        logic [2:0] exp_lvl51 = 3'd2;
`else
        int exp_n = 1;
        logic [2:0] exp_lvl51 = 3'd1;
`endif
        btn_i[BTN_CENTER] = 1'b1;
        tick(11);
        checks++;
        if ({ev_code, ev_rep, ev_level} !== {3'd4, 1'b0, 3'd1}) begin
            errors++;
            $display("FAIL rep_first: got code=%0d rep=%0b level=%0d required 4/0/1",
                     ev_code, ev_rep, ev_level);
        end
        tick(39);
        checks++;
        if (ev_level !== 3'd1) begin
            errors++;
            $display("FAIL rep_c50: got level=%0d required 1", ev_level);
        end
        tick(1);
        checks++;
        if (ev_level !== exp_lvl51) begin
            errors++;
            $display("FAIL rep_c51: got level=%0d required %0d", ev_level, exp_lvl51);
        end
        tick(99);
        btn_i[BTN_CENTER] = 1'b0;
        tick(15);
        checks++;
        if (ev_level !== 3'(exp_n)) begin
            errors++;
            $display("FAIL rep_count: got level=%0d required %0d", ev_level, exp_n);
        end
        for (int k = 0; k < exp_n; k++) begin
            checks++;
            if ({ev_code, ev_rep} !== {3'd4, (k != 0)}) begin
                errors++;
                $display("FAIL rep_entry%0d: got code=%0d rep=%0b required 4/%0b",
                         k, ev_code, ev_rep, (k != 0));
            end
            pop_once();
        end
        $display("test_autorepeat: %0d events from a 150-cycle hold", exp_n);
    endtask

    initial begin
        rstn   = 1'b0;
        btn_i  = '0;
        ev_pop = 1'b0;
        ov_clr = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_bounce();
        test_simultaneous();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_autorepeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion before 200000");
        $fatal(1, "timeout");
    end

endmodule
